// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU datapath and a host/debug loader port.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
    parameter int AW             = 8,
    parameter int DW             = 16,
    parameter int CPU_MAX_RUN    = 4,
    parameter int HOST_MAX_BURST = 8,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_stall,
    output logic             cpu_rvalid,
    output logic [DW-1:0]    cpu_rdata,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [DW-1:0]    host_wdata,
    input  logic             host_lock,
    output logic             host_gnt,
    output logic             host_rvalid,
    output logic [DW-1:0]    host_rdata,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [1:0]       arb_state,
    output logic [CNT_W-1:0] cpu_grant_cnt,
    output logic [CNT_W-1:0] host_grant_cnt,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int RUN_W   = $clog2(CPU_MAX_RUN + 1);
    localparam int BURST_W = $clog2(HOST_MAX_BURST + 1);
    localparam logic [RUN_W-1:0]   RUN_MAX   = RUN_W'(CPU_MAX_RUN);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(HOST_MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CPU   = 2'b01,
        ST_HOST  = 2'b10,
        ST_HLOCK = 2'b11
    } arb_state_t;

    arb_state_t         state_r, state_nxt_s;
    logic [RUN_W-1:0]   cpu_run_r, cpu_run_nxt_s;
    logic [BURST_W-1:0] burst_cnt_r, burst_cnt_nxt_s;
    logic               cpu_gnt_s, host_gnt_s;
    logic               cpu_rd_pend_r, host_rd_pend_r;

    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v);
        return (v >= RUN_MAX) ? RUN_MAX : v + RUN_W'(1);
    endfunction

    function automatic logic [BURST_W-1:0] burst_inc(input logic [BURST_W-1:0] v);
        return (v >= BURST_MAX) ? BURST_MAX : v + BURST_W'(1);
    endfunction

    // Grant selection: locked host burst, then starvation guard, then CPU priority.
    always_comb begin
        cpu_gnt_s  = 1'b0;
        host_gnt_s = 1'b0;
        if (!reset) begin
            cpu_gnt_s  = 1'b0;
            host_gnt_s = 1'b0;
        end else if ((state_r == ST_HLOCK) && host_req && (burst_cnt_r < BURST_MAX)) begin
            host_gnt_s = 1'b1;
        end else if (cpu_req && host_req) begin
            if (cpu_run_r >= RUN_MAX) begin
                host_gnt_s = 1'b1;
            end else begin
                cpu_gnt_s = 1'b1;
            end
        end else if (cpu_req) begin
            cpu_gnt_s = 1'b1;
        end else if (host_req) begin
            host_gnt_s = 1'b1;
        end else begin
            cpu_gnt_s  = 1'b0;
            host_gnt_s = 1'b0;
        end
    end

    // Next owner state plus the run/burst fairness counters.
    always_comb begin
        state_nxt_s     = ST_IDLE;
        cpu_run_nxt_s   = cpu_run_r;
        burst_cnt_nxt_s = {BURST_W{1'b0}};
        if (cpu_gnt_s) begin
            state_nxt_s = ST_CPU;
        end else if (host_gnt_s && host_lock) begin
            state_nxt_s = ST_HLOCK;
        end else if (host_gnt_s) begin
            state_nxt_s = ST_HOST;
        end else begin
            state_nxt_s = ST_IDLE;
        end

        if (host_gnt_s || !host_req) begin
            cpu_run_nxt_s = {RUN_W{1'b0}};
        end else if (cpu_gnt_s) begin
            cpu_run_nxt_s = run_inc(cpu_run_r);
        end else begin
            cpu_run_nxt_s = cpu_run_r;
        end

        // Entering HLOCK from elsewhere starts from a cleared count, so the first grant is 1.
        if (state_nxt_s != ST_HLOCK) begin
            burst_cnt_nxt_s = {BURST_W{1'b0}};
        end else if (host_gnt_s) begin
            burst_cnt_nxt_s = burst_inc(burst_cnt_r);
        end else begin
            burst_cnt_nxt_s = burst_cnt_r;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cpu_run_r   <= {RUN_W{1'b0}};
            burst_cnt_r <= {BURST_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cpu_run_r   <= cpu_run_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
        end
    end

    // Remember which requester issued a read so its data returns to it next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rd_pend_r  <= 1'b0;
            host_rd_pend_r <= 1'b0;
        end else begin
            cpu_rd_pend_r  <= cpu_gnt_s & ~cpu_we;
            host_rd_pend_r <= host_gnt_s & ~host_we;
        end
    end

    // Memory port drive from the granted requester; idle cycles drive zeros.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        if (cpu_gnt_s) begin
            mem_rd    = ~cpu_we;
            mem_wr    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_we ? cpu_wdata : {DW{1'b0}};
        end else if (host_gnt_s) begin
            mem_rd    = ~host_we;
            mem_wr    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_we ? host_wdata : {DW{1'b0}};
        end else begin
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = {AW{1'b0}};
            mem_wdata = {DW{1'b0}};
        end
    end

    assign cpu_gnt     = cpu_gnt_s;
    assign host_gnt    = host_gnt_s;
    assign cpu_stall   = cpu_req & ~cpu_gnt_s;
    assign cpu_rvalid  = cpu_rd_pend_r;
    assign host_rvalid = host_rd_pend_r;
    assign cpu_rdata   = cpu_rd_pend_r ? mem_rdata : {DW{1'b0}};
    assign host_rdata  = host_rd_pend_r ? mem_rdata : {DW{1'b0}};
    assign arb_state   = state_r;

`ifdef DMEM_ARB_STATS_EN
    logic [CNT_W-1:0] cpu_cnt_r, host_cnt_r, conf_cnt_r;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating grant and conflict statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_cnt_r  <= {CNT_W{1'b0}};
            host_cnt_r <= {CNT_W{1'b0}};
            conf_cnt_r <= {CNT_W{1'b0}};
        end else begin
            cpu_cnt_r  <= cpu_gnt_s ? cnt_inc(cpu_cnt_r) : cpu_cnt_r;
            host_cnt_r <= host_gnt_s ? cnt_inc(host_cnt_r) : host_cnt_r;
            conf_cnt_r <= (cpu_req && host_req) ? cnt_inc(conf_cnt_r) : conf_cnt_r;
        end
    end

    assign cpu_grant_cnt  = cpu_cnt_r;
    assign host_grant_cnt = host_cnt_r;
    assign conflict_cnt   = conf_cnt_r;
`else
    assign cpu_grant_cnt  = {CNT_W{1'b0}};
    assign host_grant_cnt = {CNT_W{1'b0}};
    assign conflict_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table, corner sequences and a random run
// against a behavioural model of the arbitration rules.
module tb_dmem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CPU_MAX_RUN = 4;
    localparam int HOST_MAX_BURST = 8;
    localparam int CNT_W = 16;
`ifdef DMEM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] cpu_addr = 8'h00, host_addr = 8'h00;
    logic [DW-1:0] cpu_wdata = 16'h0000, host_wdata = 16'h0000;
    logic cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid, mem_rd, mem_wr;
    logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = 16'h0000;
    logic [AW-1:0] mem_addr;
    logic [1:0] arb_state;
    logic [CNT_W-1:0] cpu_grant_cnt, host_grant_cnt, conflict_cnt;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .CPU_MAX_RUN(CPU_MAX_RUN),
                        .HOST_MAX_BURST(HOST_MAX_BURST), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .arb_state(arb_state),
        .cpu_grant_cnt(cpu_grant_cnt), .host_grant_cnt(host_grant_cnt),
        .conflict_cnt(conflict_cnt)
    );

    // Synchronous-read data memory the arbiter drives.
    logic [DW-1:0] env_mem [0:255];
    logic mem_clear = 1'b1;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= 16'h0000;
        end else begin
            if (mem_wr) env_mem[mem_addr] <= mem_wdata;
            if (mem_rd) mem_rdata <= env_mem[mem_addr];
        end
    end

    typedef struct {
        logic cr, cw, hr, hw, hl;
        logic [7:0] ca, ha;
        logic [15:0] cd, hd;
    } stim_t;

    typedef struct {
        stim_t s;
        logic eg_c, eg_h;
        logic [1:0] est;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state, expressed in terms of requester history.
    logic [15:0] ref_mem [0:255];
    int  m_streak, m_burst, m_cpu_cnt, m_host_cnt, m_conf_cnt;
    logic [1:0] m_owner;
    bit  m_crv, m_hrv;
    logic [15:0] m_crd, m_hrd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_streak = 0; m_burst = 0; m_owner = 2'b00;
        m_crv = 1'b0; m_hrv = 1'b0; m_crd = 16'h0000; m_hrd = 16'h0000;
        m_cpu_cnt = 0; m_host_cnt = 0; m_conf_cnt = 0;
    endtask

    function automatic stim_t mk(input logic cr, input logic cw, input logic [7:0] ca,
                                 input logic [15:0] cd, input logic hr, input logic hw,
                                 input logic [7:0] ha, input logic [15:0] hd, input logic hl);
        stim_t s;
        s.cr = cr; s.cw = cw; s.ca = ca; s.cd = cd;
        s.hr = hr; s.hw = hw; s.ha = ha; s.hd = hd; s.hl = hl;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic c, input logic h,
                                 input logic [1:0] st);
        vec_t v;
        v.s = s; v.eg_c = c; v.eg_h = h; v.est = st;
        return v;
    endfunction

    // One clock cycle: drive at negedge, compare against the model, then advance the model.
    task automatic run_cycle(input stim_t s, output bit ec, output bit eh);
        bit e_rd, e_wr;
        logic [7:0] e_addr;
        logic [15:0] e_wd;
        @(negedge clk);
        cpu_req = s.cr; cpu_we = s.cw; cpu_addr = s.ca; cpu_wdata = s.cd;
        host_req = s.hr; host_we = s.hw; host_addr = s.ha; host_wdata = s.hd; host_lock = s.hl;
        #1;
        if (m_owner == 2'b11 && s.hr && m_burst < HOST_MAX_BURST) begin
            eh = 1'b1; ec = 1'b0;
        end else if (s.cr && s.hr) begin
            eh = (m_streak >= CPU_MAX_RUN); ec = !eh;
        end else begin
            ec = s.cr; eh = s.hr;
        end
        e_rd   = (ec && !s.cw) || (eh && !s.hw);
        e_wr   = (ec && s.cw) || (eh && s.hw);
        e_addr = ec ? s.ca : (eh ? s.ha : 8'h00);
        e_wd   = (ec && s.cw) ? s.cd : ((eh && s.hw) ? s.hd : 16'h0000);
        check("cpu_gnt", cpu_gnt, ec);
        check("host_gnt", host_gnt, eh);
        check("cpu_stall", cpu_stall, s.cr && !ec);
        check("mem_rd", mem_rd, e_rd);
        check("mem_wr", mem_wr, e_wr);
        check("mem_addr", mem_addr, e_addr);
        if (!e_rd) check("mem_wdata", mem_wdata, e_wd);
        check("cpu_rvalid", cpu_rvalid, m_crv);
        check("cpu_rdata", cpu_rdata, m_crv ? m_crd : 16'h0000);
        check("host_rvalid", host_rvalid, m_hrv);
        check("host_rdata", host_rdata, m_hrv ? m_hrd : 16'h0000);
        check("arb_state", arb_state, m_owner);
        if (ec && m_cpu_cnt < 65535) m_cpu_cnt++;
        if (eh && m_host_cnt < 65535) m_host_cnt++;
        if (s.cr && s.hr && m_conf_cnt < 65535) m_conf_cnt++;
        m_crv = ec && !s.cw; m_crd = ref_mem[s.ca];
        m_hrv = eh && !s.hw; m_hrd = ref_mem[s.ha];
        if (ec && s.cw) ref_mem[s.ca] = s.cd;
        if (eh && s.hw) ref_mem[s.ha] = s.hd;
        if (eh || !s.hr) m_streak = 0;
        else if (ec && m_streak < CPU_MAX_RUN) m_streak++;
        m_owner = ec ? 2'b01 : (eh ? (s.hl ? 2'b11 : 2'b10) : 2'b00);
        if (m_owner != 2'b11) m_burst = 0;
        else if (m_burst < HOST_MAX_BURST) m_burst++;
    endtask

    task automatic check_stats();
        check("cpu_grant_cnt", 32'(cpu_grant_cnt), STATS ? 32'(m_cpu_cnt) : 32'd0);
        check("host_grant_cnt", 32'(host_grant_cnt), STATS ? 32'(m_host_cnt) : 32'd0);
        check("conflict_cnt", 32'(conflict_cnt), STATS ? 32'(m_conf_cnt) : 32'd0);
    endtask

    vec_t tbl[$];
    stim_t idle_s;

    initial begin
        bit ec, eh, c_pend, h_pend, lock_mode;
        stim_t s;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        model_reset();
        idle_s = mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);

        // Reset held low with both requesters asking.
        cpu_req = 1'b1; host_req = 1'b1; host_lock = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_clear = 1'b0;
        #1;
        check("rst_cpu_gnt", cpu_gnt, 1'b0);
        check("rst_host_gnt", host_gnt, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        check("rst_host_rvalid", host_rvalid, 1'b0);
        check("rst_arb_state", arb_state, 2'b00);
        cpu_req = 1'b0; host_req = 1'b0; host_lock = 1'b0;
        reset = 1'b1;

        // Fairness rotation, then a locked host burst broken by the CPU.
        for (int i = 0; i < 10; i++) begin
            bit h;
            h = (i == 4) || (i == 9);
            tbl.push_back(mkv(mk(1'b1, 1'b0, 8'h30, 16'h0000, 1'b1, 1'b0, 8'h40, 16'h0000, 1'b0),
                              !h, h, (i == 0) ? 2'b00 : ((i == 5) ? 2'b10 : 2'b01)));
        end
        tbl.push_back(mkv(idle_s, 1'b0, 1'b0, 2'b10));
        tbl.push_back(mkv(mk(1'b0, 1'b0, 8'h60, 16'h0000, 1'b1, 1'b1, 8'h20, 16'hA020, 1'b1),
                          1'b0, 1'b1, 2'b00));
        for (int j = 1; j < 8; j++)
            tbl.push_back(mkv(mk(1'b1, 1'b0, 8'h60, 16'h0000, 1'b1, 1'b1, 8'(8'h20 + j),
                                 16'(16'hA020 + j), 1'b1), 1'b0, 1'b1, 2'b11));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mkv(mk(1'b1, 1'b0, 8'h60, 16'h0000, 1'b1, 1'b1, 8'h28, 16'hA028, 1'b1),
                              1'b1, 1'b0, (k == 0) ? 2'b11 : 2'b01));
        tbl.push_back(mkv(mk(1'b1, 1'b0, 8'h60, 16'h0000, 1'b1, 1'b1, 8'h28, 16'hA028, 1'b1),
                          1'b0, 1'b1, 2'b01));
        tbl.push_back(mkv(mk(1'b1, 1'b0, 8'h60, 16'h0000, 1'b1, 1'b1, 8'h29, 16'hA029, 1'b1),
                          1'b0, 1'b1, 2'b11));
        tbl.push_back(mkv(idle_s, 1'b0, 1'b0, 2'b11));
        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i].s, ec, eh);
            check($sformatf("tbl%0d_cpu_gnt", i), cpu_gnt, tbl[i].eg_c);
            check($sformatf("tbl%0d_host_gnt", i), host_gnt, tbl[i].eg_h);
            check($sformatf("tbl%0d_arb_state", i), arb_state, tbl[i].est);
        end

        // CPU read returns data one cycle after issue.
        run_cycle(mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0), ec, eh);
        run_cycle(mk(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0), ec, eh);
        check("t2_cpu_gnt", cpu_gnt, 1'b1);
        check("t2_mem_rd", mem_rd, 1'b1);
        check("t2_mem_addr", mem_addr, 8'h10);
        run_cycle(idle_s, ec, eh);
        check("t2_cpu_rvalid", cpu_rvalid, 1'b1);
        check("t2_cpu_rdata", cpu_rdata, 16'hBEEF);
        check("t2_host_rvalid", host_rvalid, 1'b0);

        // Host write followed immediately by a CPU read of the same word.
        run_cycle(mk(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h55, 16'h1234, 1'b0), ec, eh);
        run_cycle(mk(1'b1, 1'b0, 8'h55, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0), ec, eh);
        run_cycle(idle_s, ec, eh);
        check("t5_cpu_rdata", cpu_rdata, 16'h1234);

        // Random traffic obeying the hold-until-granted request protocol.
        c_pend = 1'b0; h_pend = 1'b0; lock_mode = 1'b0; s = idle_s;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) lock_mode = 1'($urandom_range(0, 1));
            if (!c_pend) begin
                s.cr = ($urandom_range(0, 99) < 65);
                s.cw = 1'($urandom_range(0, 1));
                s.ca = 8'($urandom_range(0, 15));
                s.cd = 16'($urandom);
            end
            if (!h_pend) begin
                s.hr = ($urandom_range(0, 99) < (lock_mode ? 85 : 50));
                s.hw = 1'($urandom_range(0, 1));
                s.ha = 8'($urandom_range(8, 23));
                s.hd = 16'($urandom);
                s.hl = lock_mode && ($urandom_range(0, 7) != 0);
            end
            run_cycle(s, ec, eh);
            c_pend = s.cr && !ec;
            h_pend = s.hr && !eh;
        end
        run_cycle(idle_s, ec, eh);
        check_stats();

        // Reset asserted the cycle after a read grant suppresses its rvalid.
        run_cycle(mk(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0), ec, eh);
        check("t6_cpu_gnt", cpu_gnt, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_req = 1'b0;
        model_reset();
        @(negedge clk);
        check("t6_cpu_rvalid", cpu_rvalid, 1'b0);
        check("t6_arb_state", arb_state, 2'b00);
        reset = 1'b1;
        #1;
        check_stats();
        run_cycle(mk(1'b1, 1'b0, 8'h55, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0), ec, eh);
        run_cycle(idle_s, ec, eh);
        check("t6_post_rdata", cpu_rdata, 16'h1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
